// File: rtl/seq_mul.sv
// Iterative shift-and-add multiplier: one multiplier bit per clock, WIDTH-cycle fixed latency.
// Optional SEQ_MUL_SIGNED_EN adds a signed_op input for two's-complement operands.
module seq_mul #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic                 sign_q, sign_d;

  logic [WIDTH-1:0]     op1, op2;
  logic                 op_sign;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   result;

  // Operands are reduced to magnitudes at capture; the iteration itself is always unsigned.
`ifdef SEQ_MUL_SIGNED_EN
  always_comb begin
    op1     = (signed_op && in1[WIDTH-1]) ? (~in1 + WIDTH'(1)) : in1;
    op2     = (signed_op && in2[WIDTH-1]) ? (~in2 + WIDTH'(1)) : in2;
    op_sign = signed_op & (in1[WIDTH-1] ^ in2[WIDTH-1]);
  end
`else
  always_comb begin
    op1     = in1;
    op2     = in2;
    op_sign = 1'b0;
  end
`endif

  always_comb begin
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    result  = sign_q ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = out_q;
    sign_d   = sign_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, op1};
          mplier_d = op2;
          sign_d   = op_sign;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          out_d   = result;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
      sign_q   <= sign_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul at WIDTH=8.
module tb_seq_mul;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   in1 = '0;
  logic [W-1:0]   in2 = '0;
  logic           signed_op = 1'b0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;

  int total = 0;
  int bad   = 0;

  seq_mul #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op(signed_op),
`endif
    .busy     (busy),
    .done     (done),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accepted start to done, and busy-high cycles on the way.
  task automatic wait_done(output int n, output int busy_cyc, output bit out_moved);
    logic [2*W-1:0] held;
    held      = out;
    n         = 0;
    busy_cyc  = 0;
    out_moved = 1'b0;
    while (!done && n < 20) begin
      if (busy) busy_cyc++;
      if (out !== held) out_moved = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] exp);
    int n, bc;
    bit moved;
    in1 = a; in2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc, moved);
    chk({tag, " latency"}, n, W);
    chk({tag, " busy_cycles"}, bc, W);
    chk({tag, " out_held"}, {31'd0, moved}, 0);
    chk({tag, " out"}, out, exp);
    tick();
    chk({tag, " done_low"}, {31'd0, done}, 0);
  endtask

  initial begin
    int n, bc, dones;
    bit moved;

    rst = 1'b1;
    #12;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset out", out, 0);
    rst = 1'b0;
    tick();

    mul("255x255", 8'd255, 8'd255, 16'hFE01);
    mul("0x173", 8'd0, 8'd173, 16'd0);
    mul("13x11", 8'd13, 8'd11, 16'd143);

    // Requests and operand changes while busy must be ignored.
    in1 = 8'd12; in2 = 8'd10; start = 1'b1;
    tick();
    in1 = 8'd7; in2 = 8'd7;
    tick();
    in1 = 8'd3; in2 = 8'd200;
    tick();
    start = 1'b0;
    wait_done(n, bc, moved);
    chk("busy_ignore latency", n, W - 2);
    chk("busy_ignore out", out, 16'd120);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    chk("busy_ignore extra_done", dones, 0);

    // Asynchronous reset in the 4th RUN cycle.
    in1 = 8'd200; in2 = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("async_rst busy", {31'd0, busy}, 0);
    chk("async_rst done", {31'd0, done}, 0);
    chk("async_rst out", out, 0);
    tick();
    rst = 1'b0;
    tick();
    mul("5x6", 8'd5, 8'd6, 16'd30);

    // Back-to-back: new start in the done cycle.
    in1 = 8'd9; in2 = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc, moved);
    chk("b2b first latency", n, W);
    chk("b2b first out", out, 16'd81);
    in1 = 8'd2; in2 = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b done_low", {31'd0, done}, 0);
    chk("b2b busy", {31'd0, busy}, 1);
    wait_done(n, bc, moved);
    chk("b2b second latency", n, W);
    chk("b2b second out", out, 16'd200);
    tick();

`ifdef SEQ_MUL_SIGNED_EN
    signed_op = 1'b1;
    mul("s -3x5", 8'hFD, 8'h05, 16'hFFF1);
    mul("s -128x-128", 8'h80, 8'h80, 16'h4000);
    signed_op = 1'b0;
    mul("u 253x5", 8'hFD, 8'h05, 16'h04F1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
